// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU issue front-end: unit indices, controller
// states and the default integer-destination mask.
package fpu_pkg;

    localparam int DATA_W = 32;

    // Functional unit slots; the issue op is the unit index.
    localparam int FU_FEQ  = 0;
    localparam int FU_FLT  = 1;
    localparam int FU_FLE  = 2;
    localparam int FU_FADD = 3;
    localparam int FU_FMUL = 4;
    localparam int FU_FDIV = 5;

    // Compares write the integer regfile, everything else the FP regfile.
    localparam logic [7:0] DEF_INT_DST_MASK = 8'b0000_0111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT
    } state_t;

    // One spare bit so the wait counter can reach TIMEOUT-1 without wrapping.
    function automatic int cnt_width(input int timeout);
        return $clog2(timeout) + 1;
    endfunction

endpackage

// File: rtl/fpu_result_mux.sv
// Selects one unit's 32-bit result out of the flattened result bus.
module fpu_result_mux
    import fpu_pkg::*;
#(
    parameter int NUM_FU = 8,
    parameter int OPW    = 3
) (
    input  logic [OPW-1:0]           sel,
    input  logic [DATA_W*NUM_FU-1:0] results,
    output logic [DATA_W-1:0]        result
);

    always_comb begin
        result = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            if (sel == OPW'(i))
                result = results[DATA_W*i +: DATA_W];
        end
    end

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Single-op sequencer: latch op, pulse the unit's enable, wait for its ready
// (bounded by TIMEOUT), then emit a one-cycle registered writeback.
module fpu_issue_ctrl
    import fpu_pkg::*;
#(
    parameter int                NUM_FU       = 8,
    parameter int                TIMEOUT      = 64,
    parameter logic [NUM_FU-1:0] INT_DST_MASK = DEF_INT_DST_MASK,
    parameter int                RD_W         = 5
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        issue_valid,
    output logic                        issue_ready,
    input  logic [$clog2(NUM_FU)-1:0]   issue_op,
    input  logic [DATA_W-1:0]           issue_a,
    input  logic [DATA_W-1:0]           issue_b,
    input  logic [RD_W-1:0]             issue_rd,
    output logic [DATA_W-1:0]           fu_a,
    output logic [DATA_W-1:0]           fu_b,
    output logic [NUM_FU-1:0]           fu_en,
    input  logic [NUM_FU-1:0]           fu_ready,
    input  logic [DATA_W*NUM_FU-1:0]    fu_result,
    output logic                        wb_valid,
    output logic [DATA_W-1:0]           wb_data,
    output logic [RD_W-1:0]             wb_rd,
    output logic                        wb_to_int,
    output logic                        err
);

    localparam int OPW    = $clog2(NUM_FU);
    localparam int NOPS   = 1 << OPW;
    localparam int CW     = cnt_width(TIMEOUT);
    // Last WAIT cycle still allowed to see ready; missing it means timeout.
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 2);

    state_t            state;
    logic [OPW-1:0]    op_q;
    logic [RD_W-1:0]   rd_q;
    logic [CW-1:0]     cnt;
    logic [DATA_W-1:0] sel_result;
    logic [NOPS-1:0]   op_legal;
    logic              accept;

    // Encodings beyond NUM_FU exist whenever NUM_FU is not a power of two.
    for (genvar i = 0; i < NOPS; i++) begin : g_legal
        assign op_legal[i] = (i < NUM_FU);
    end

    assign issue_ready = (state == S_IDLE);
    assign accept      = issue_valid & issue_ready;

    fpu_result_mux #(
        .NUM_FU (NUM_FU),
        .OPW    (OPW)
    ) u_result_mux (
        .sel     (op_q),
        .results (fu_result),
        .result  (sel_result)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            op_q      <= '0;
            rd_q      <= '0;
            cnt       <= '0;
            fu_a      <= '0;
            fu_b      <= '0;
            fu_en     <= '0;
            wb_valid  <= 1'b0;
            wb_data   <= '0;
            wb_rd     <= '0;
            wb_to_int <= 1'b0;
            err       <= 1'b0;
        end else begin
            fu_en    <= '0;
            wb_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (op_legal[issue_op]) begin
                            op_q  <= issue_op;
                            rd_q  <= issue_rd;
                            fu_a  <= issue_a;
                            fu_b  <= issue_b;
                            fu_en <= NUM_FU'(1) << issue_op;
                            state <= S_ISSUE;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                // Units have latency >= 1, so ready is not looked at here.
                S_ISSUE: begin
                    cnt   <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (fu_ready[op_q]) begin
                        wb_valid  <= 1'b1;
                        wb_data   <= sel_result;
                        wb_rd     <= rd_q;
                        wb_to_int <= INT_DST_MASK[op_q];
                        state     <= S_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (cnt == CNT_LAST) begin
                            err   <= 1'b1;
                            state <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Self-checking bench for fpu_issue_ctrl: directed table, reset corner case,
// and randomized ops checked against a rule-level reference model.
module tb_fpu_issue_ctrl;
    import fpu_pkg::*;

    localparam int NF = 6;
    localparam int TO = 20;
    localparam int RW = 5;
    localparam int OW = 3;
    localparam logic [NF-1:0] MASK = 6'b000111;

    logic              clk = 1'b0;
    logic              rst;
    logic              issue_valid, issue_ready;
    logic [OW-1:0]     issue_op;
    logic [31:0]       issue_a, issue_b;
    logic [RW-1:0]     issue_rd;
    logic [31:0]       fu_a, fu_b;
    logic [NF-1:0]     fu_en, fu_ready;
    logic [32*NF-1:0]  fu_result;
    logic              wb_valid, wb_to_int, err;
    logic [31:0]       wb_data;
    logic [RW-1:0]     wb_rd;

    always #5 clk = ~clk;

    fpu_issue_ctrl #(
        .NUM_FU       (NF),
        .TIMEOUT      (TO),
        .INT_DST_MASK (MASK),
        .RD_W         (RW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .issue_op    (issue_op),
        .issue_a     (issue_a),
        .issue_b     (issue_b),
        .issue_rd    (issue_rd),
        .fu_a        (fu_a),
        .fu_b        (fu_b),
        .fu_en       (fu_en),
        .fu_ready    (fu_ready),
        .fu_result   (fu_result),
        .wb_valid    (wb_valid),
        .wb_data     (wb_data),
        .wb_rd       (wb_rd),
        .wb_to_int   (wb_to_int),
        .err         (err)
    );

    typedef struct {
        bit            pre_rst;
        logic [OW-1:0] op;
        logic [31:0]   a;
        logic [31:0]   b;
        logic [RW-1:0] rd;
        int            lat;
        logic [31:0]   res;
        bit            exp_wb;
        logic [31:0]   exp_data;
        bit            exp_int;
        int            exp_done;   // cycles after accept until issue_ready returns
        bit            exp_err;
    } vec_t;

    int checks = 0;
    int fails  = 0;

    // Architectural state the bench expects the DUT to hold between ops.
    bit            err_m;
    logic [31:0]   data_m, fa_m, fb_m;
    logic [RW-1:0] rd_m;
    bit            int_m;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        err_m  = 1'b0;
        data_m = '0;
        rd_m   = '0;
        int_m  = 1'b0;
        fa_m   = '0;
        fb_m   = '0;
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        issue_valid = 1'b0;
        fu_ready    = '0;
        #2;
        chk("rst_fu_en", 32'(fu_en), 32'd0);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_wb_rd", 32'(wb_rd), 32'd0);
        chk("rst_wb_to_int", 32'(wb_to_int), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_fu_a", fu_a, 32'd0);
        chk("rst_fu_b", fu_b, 32'd0);
        chk("rst_issue_ready", 32'(issue_ready), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    function automatic vec_t mk(input int op, input logic [31:0] a, input logic [31:0] b,
                                input int rd, input int lat, input logic [31:0] res,
                                input int wb, input logic [31:0] data, input int to_int,
                                input int done, input int e, input int pr);
        vec_t v;
        v.pre_rst  = (pr != 0);
        v.op       = OW'(op);
        v.a        = a;
        v.b        = b;
        v.rd       = RW'(rd);
        v.lat      = lat;
        v.res      = res;
        v.exp_wb   = (wb != 0);
        v.exp_data = data;
        v.exp_int  = (to_int != 0);
        v.exp_done = done;
        v.exp_err  = (e != 0);
        return v;
    endfunction

    // Reference: a legal op completes if its unit answers within TIMEOUT-1
    // cycles of the enable; otherwise (or if illegal) err becomes set.
    function automatic vec_t model(input logic [OW-1:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input logic [RW-1:0] rd,
                                   input int lat, input logic [31:0] res);
        vec_t v;
        bit legal;
        bit fin;
        legal      = (int'(op) < NF);
        fin        = legal && (lat <= TO - 1);
        v.pre_rst  = 1'b0;
        v.op       = op;
        v.a        = a;
        v.b        = b;
        v.rd       = rd;
        v.lat      = lat;
        v.res      = res;
        v.exp_wb   = fin;
        v.exp_data = res;
        v.exp_int  = legal ? MASK[op] : 1'b0;
        v.exp_done = !legal ? 1 : (fin ? lat + 2 : TO + 1);
        v.exp_err  = err_m | !fin;
        return v;
    endfunction

    task automatic exec(input vec_t v);
        bit legal;
        logic [NF-1:0] r;
        legal = (int'(v.op) < NF);
        chk("issue_ready_at_accept", 32'(issue_ready), 32'd1);
        issue_valid = 1'b1;
        issue_op    = v.op;
        issue_a     = v.a;
        issue_b     = v.b;
        issue_rd    = v.rd;
        for (int i = 0; i < NF; i++)
            fu_result[32*i +: 32] = (int'(v.op) == i) ? v.res : $urandom;
        fu_ready = NF'($urandom);
        tick();
        // Scramble the issue bus: the DUT must not re-sample after accept.
        issue_valid = 1'b0;
        issue_op    = OW'($urandom);
        issue_a     = $urandom;
        issue_b     = $urandom;
        issue_rd    = RW'($urandom);
        if (legal) begin
            fa_m = v.a;
            fb_m = v.b;
        end
        for (int c = 1; c <= v.exp_done; c++) begin
            r = NF'($urandom);
            if (c >= 2 && legal)
                r[v.op] = (c - 1 == v.lat);
            fu_ready = r;
            chk("fu_en", 32'(fu_en), (legal && c == 1) ? (32'd1 << v.op) : 32'd0);
            chk("issue_ready", 32'(issue_ready), 32'(c == v.exp_done));
            chk("err", 32'(err), 32'(c == v.exp_done ? v.exp_err : err_m));
            chk("fu_a", fu_a, fa_m);
            chk("fu_b", fu_b, fb_m);
            if (c == v.exp_done && v.exp_wb) begin
                chk("wb_valid", 32'(wb_valid), 32'd1);
                chk("wb_data", wb_data, v.exp_data);
                chk("wb_rd", 32'(wb_rd), 32'(v.rd));
                chk("wb_to_int", 32'(wb_to_int), 32'(v.exp_int));
            end else begin
                chk("wb_valid_idle", 32'(wb_valid), 32'd0);
                chk("wb_data_hold", wb_data, data_m);
                chk("wb_rd_hold", 32'(wb_rd), 32'(rd_m));
                chk("wb_to_int_hold", 32'(wb_to_int), 32'(int_m));
            end
            if (c < v.exp_done)
                tick();
        end
        fu_ready = '0;
        err_m    = v.exp_err;
        if (v.exp_wb) begin
            data_m = v.exp_data;
            rd_m   = v.rd;
            int_m  = v.exp_int;
        end
    endtask

    vec_t tbl[10];
    vec_t rv;

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        issue_valid = 1'b0;
        issue_op    = '0;
        issue_a     = '0;
        issue_b     = '0;
        issue_rd    = '0;
        fu_ready    = '0;
        fu_result   = '0;

        //             op       a             b             rd lat    res           wb data          int done    err rst
        tbl[0] = mk(FU_FEQ,  32'h3F80_0000, 32'h3F80_0000, 7,  1,   32'h1,         1, 32'h1,         1, 3,      0, 0);
        tbl[1] = mk(FU_FDIV, 32'h4080_0000, 32'h4000_0000, 3,  10,  32'h4000_0000, 1, 32'h4000_0000, 0, 12,     0, 0);
        tbl[2] = mk(FU_FLT,  32'h3F80_0000, 32'h4000_0000, 31, 2,   32'h1,         1, 32'h1,         1, 4,      0, 0);
        tbl[3] = mk(FU_FADD, 32'h3F80_0000, 32'h4000_0000, 0,  4,   32'h4040_0000, 1, 32'h4040_0000, 0, 6,      0, 0);
        tbl[4] = mk(FU_FMUL, 32'h4000_0000, 32'h4040_0000, 12, TO-1,32'h40C0_0000, 1, 32'h40C0_0000, 0, TO + 1, 0, 0);
        tbl[5] = mk(6,       32'h1111_1111, 32'h2222_2222, 4,  1,   32'h0,         0, 32'h0,         0, 1,      1, 0);
        tbl[6] = mk(FU_FEQ,  32'h3F80_0000, 32'h4000_0000, 9,  1,   32'h0,         1, 32'h0,         1, 3,      1, 0);
        tbl[7] = mk(FU_FLE,  32'h4000_0000, 32'h3F80_0000, 9,  TO,  32'hDEAD_BEEF, 0, 32'h0,         0, TO + 1, 1, 1);
        tbl[8] = mk(FU_FDIV, 32'h4100_0000, 32'h4000_0000, 17, 3,   32'h4080_0000, 1, 32'h4080_0000, 0, 5,      1, 0);
        tbl[9] = mk(7,       32'h3333_3333, 32'h4444_4444, 2,  1,   32'h0,         0, 32'h0,         0, 1,      1, 1);

        do_reset();
        for (int i = 0; i < 10; i++) begin
            if (tbl[i].pre_rst)
                do_reset();
            exec(tbl[i]);
        end

        // Reset while an fdiv is in WAIT; its late ready must be dropped.
        do_reset();
        issue_valid = 1'b1;
        issue_op    = OW'(FU_FDIV);
        issue_a     = 32'h4080_0000;
        issue_b     = 32'h4000_0000;
        issue_rd    = 5'd3;
        fu_result[32*FU_FDIV +: 32] = 32'h4000_0000;
        tick();
        issue_valid = 1'b0;
        tick();
        tick();
        chk("midwait_busy", 32'(issue_ready), 32'd0);
        #3;
        do_reset();
        fu_ready[FU_FDIV] = 1'b1;
        tick();
        fu_ready = '0;
        chk("late_ready_wb", 32'(wb_valid), 32'd0);
        chk("late_ready_en", 32'(fu_en), 32'd0);
        tick();
        chk("late_ready_wb2", 32'(wb_valid), 32'd0);
        chk("late_ready_err", 32'(err), 32'd0);
        exec(mk(FU_FEQ, 32'h3F80_0000, 32'h3F80_0000, 5, 1, 32'h1, 1, 32'h1, 1, 3, 0, 0));
        exec(mk(FU_FEQ, 32'h3F80_0000, 32'h4000_0000, 6, 1, 32'h0, 1, 32'h0, 1, 3, 0, 0));

        // Randomized ops against the rule-level model.
        do_reset();
        for (int n = 0; n < 60; n++) begin
            int sel;
            int lat;
            sel = int'($urandom_range(0, 9));
            lat = (sel == 0) ? TO + 3 : (sel == 1) ? TO - 1 : int'($urandom_range(1, 8));
            rv = model(OW'($urandom_range(0, 7)), $urandom, $urandom,
                       RW'($urandom), lat, $urandom);
            exec(rv);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
